spi_eeprom_slave: RTL and testbench
===================================

// Module: spi_eeprom_slave
// PURPOSE
//  Synthesizable SPI mode-0 target that emulates the 128x8 M25AA010A serial EEPROM command subset.
//  Sits on the far end of the spi master bus and is clocked by the system clock.
//  SCK/CS_N/SI are oversampled; SCK must be <= clk_50M/8.
//  Serves as an FPGA-side EEPROM stand-in and as a loopback target for master tests.
// PARAMETERS
//  ADDR_W       7        byte address width; array depth = 2**ADDR_W
//  PAGE_W       4        page offset width; page = 16 bytes
//  WRITE_CYCLES 250000   clk_50M cycles WIP stays set after a commit (5 ms)
// PORTS
//  clk_50M    in   1   system clock
//  reset      in   1   asynchronous reset, active-high
//  spi_csn    in   1   chip select, active-low
//  spi_sck    in   1   serial clock, idle low
//  spi_si     in   1   serial data from master (MOSI)
//  spi_so     out  1   serial data to master (MISO); valid only while spi_so_oe=1
//  spi_so_oe  out  1   SO drive enable; the top level builds the tri-state
//  busy       out  1   mirror of status WIP
//  wr_commit  out  1   one-cycle pulse when a page write starts
// BEHAVIOUR
//  Reset values: spi_so=0, spi_so_oe=0, busy=0, wr_commit=0; WEL=0, WIP=0; FSM in IDLE; page buffer cleared.
//  Array contents are not reset.
//  Input sync: 2-flop synchronizers on csn/sck/si; edge detect on the synced sck.
//  SI is sampled on the sck rising edge (MSB first); SO updates on the sck falling edge.
//  CS_N high at any time: FSM returns to IDLE, spi_so_oe=0, and bit/byte counters clear.
//  FSM states:
//    IDLE     -> CMD on CS_N falling.
//    CMD      8 bits -> opcode decode.
//    ADDR     8 bits; MSB ignored; address = low ADDR_W bits.
//    RD_DATA  stream array bytes.
//    WR_DATA  load page buffer.
//    STAT     stream the status register.
//    WAITCS   swallow bits until CS_N rises.
//  Opcodes (from pkg): 03 READ, 02 WRITE, 06 WREN, 04 WRDI, 05 RDSR, 01 WRSR.
//  Status register = {6'b0, WEL, WIP}; no block protect.
//  WRSR is accepted and its data is discarded (WAITCS).
//  Unknown opcode -> WAITCS, SO stays high-Z.
//  While WIP=1, only RDSR is honoured; every other opcode -> WAITCS.
//  WREN/WRDI: set/clear WEL on CS_N rise, only if exactly 8 bits were clocked; otherwise no effect.
//  READ: first data MSB driven on the falling sck after the last address bit; spi_so_oe rises at that edge.
//    Address auto-increments per byte and wraps from 2**ADDR_W-1 to 0.
//  RDSR: status MSB driven on the falling sck after the 8th opcode bit; the byte repeats while CS_N is low.
//    WIP/WEL are resampled at each byte boundary.
//  WRITE:
//    Requires WEL=1 at opcode decode; otherwise -> WAITCS.
//    Each full data byte goes to page buffer[offset]; offset = addr[PAGE_W-1:0] and wraps within the page.
//    More than 16 bytes: later bytes overwrite earlier ones.
//    Commit on CS_N rise only if >=1 data byte was received AND the bit count is a multiple of 8.
//    On commit: buffered bytes (valid mask) are written to the array, 1 byte/clk.
//    Also on commit: WIP=1, WEL=0, wr_commit pulses, counter loads WRITE_CYCLES.
//    WIP clears when the counter reaches 0.
//    Partial final byte or zero data bytes: no commit, WEL unchanged, buffer discarded.
//  Simultaneous: a CS_N rise on the same clk as the 8th sck rise counts that bit as received.
//  Reset mid-busy: WIP cleared; the pending write is lost; the array is left as-is.
// STRUCTURE
//  spi_eeprom_pkg: opcode localparams, status bit indices, FSM state encoding.
//  Sub-module spi_eeprom_mem: 2**ADDR_W x 8 simple dual-port RAM.
//    Sync write port used by the commit sequencer; sync read port used by the READ streamer.
//    Prefetch the next byte during bit 7 so it is ready for the next falling edge.
//  Top level holds: synchronizers, shift registers, FSM, 16x8 page buffer + valid mask, WIP counter.
// TESTING (bench uses WRITE_CYCLES=100, SCK=clk/10, pairs with the spi master)
//  1 Reset, then RDSR -> 0x00; spi_so_oe=0 outside the data phase; busy=0.
//  2 WREN, RDSR -> 0x02; WRDI, RDSR -> 0x00; WREN with 7 bits then CS high -> RDSR 0x00.
//  3 WREN; WRITE 00 78; CS high -> wr_commit pulse; RDSR during busy -> 0x01.
//    After 100 clk -> 0x00; READ 00 -> 0x78.
//  4 WRITE 01 9A without WREN -> no wr_commit; READ 01 -> 0xFF (preloaded); RDSR -> 0x00.
//  5 WREN; WRITE 0E 11 22 33 -> READ 0E gives 11 22, and byte 00 = 33.
//    READ 7F over two bytes -> mem[7F], mem[00].
//  6 WREN; WRITE 02 BC + 3 bits, CS high -> no commit, WEL=1.
//    Then a valid write, and assert reset during busy -> busy=0, RDSR -> 0x00.

Source files
------------

// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes, status bit positions and FSM encodings for the SPI EEPROM target.
// Opcode decode helpers keep the FSM and datapath agreeing on what each command does.
package spi_eeprom_pkg;

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_STAT    = 3'd5,
        ST_WAITCS  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_WREN = 2'd1,
        PEND_WRDI = 2'd2
    } pend_t;

    // While a page write is in progress only the status read is honoured.
    function automatic state_t cmd_next_state(input logic [7:0] op,
                                              input logic       wel,
                                              input logic       wip);
        if (op == OP_RDSR) return ST_STAT;
        if (wip) return ST_WAITCS;
        if (op == OP_READ) return ST_ADDR;
        if (op == OP_WRITE && wel) return ST_ADDR;
        return ST_WAITCS;
    endfunction

    function automatic pend_t cmd_pend(input logic [7:0] op, input logic wip);
        if (wip) return PEND_NONE;
        if (op == OP_WREN) return PEND_WREN;
        if (op == OP_WRDI) return PEND_WRDI;
        return PEND_NONE;
    endfunction

endpackage

// File: rtl/spi_eeprom_mem.sv
// Byte-wide simple dual-port array backing the emulated EEPROM.
// Contents are deliberately not reset; the read port is registered.
module spi_eeprom_mem #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_array [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem_array[waddr] <= wdata;
        rdata <= mem_array[raddr];
    end

endmodule

// File: rtl/spi_eeprom_slave.sv
// Oversampled SPI mode-0 target emulating a 128x8 serial EEPROM command subset.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | CS_N high, waiting for a falling edge
//   ST_CMD     | shifting in the 8-bit opcode
//   ST_ADDR    | shifting in the byte address (MSB ignored)
//   ST_RD_DATA | streaming array bytes, address auto-increments and wraps
//   ST_WR_DATA | collecting data bytes into the page buffer
//   ST_STAT    | streaming the status register, resampled every byte
//   ST_WAITCS  | ignoring bits until CS_N rises
module spi_eeprom_slave
    import spi_eeprom_pkg::*;
#(
    parameter int ADDR_W       = 7,
    parameter int PAGE_W       = 4,
    parameter int WRITE_CYCLES = 250000
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic spi_csn,
    input  logic spi_sck,
    input  logic spi_si,
    output logic spi_so,
    output logic spi_so_oe,
    output logic busy,
    output logic wr_commit
);

    localparam int PAGE_DEPTH = 2**PAGE_W;
    localparam int PAGE_NUM_W = ADDR_W - PAGE_W;
    localparam int CNT_W      = $clog2(WRITE_CYCLES + 1);

    logic [1:0] csn_sync, sck_sync, si_sync;
    logic       csn_s, sck_s, si_s, csn_d, sck_d;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;

    state_t state, state_nxt;
    pend_t  op_pend, eff_pend;

    logic [2:0]            bit_cnt;
    logic [6:0]            rx_sr;
    logic [7:0]            rx_byte;
    logic                  byte_done;
    logic [6:0]            tx_sr;
    logic [7:0]            tx_byte;
    logic [7:0]            status;
    logic                  is_write;
    logic                  got_byte;
    logic                  commit_go;

    logic                  wel, wip;
    logic [CNT_W-1:0]      wip_cnt;

    logic [7:0]            pbuf [PAGE_DEPTH];
    logic [PAGE_DEPTH-1:0] pvalid;
    logic [PAGE_W-1:0]     wr_off;
    logic [PAGE_NUM_W-1:0] wr_page;
    logic                  commit_act;
    logic [PAGE_W-1:0]     commit_idx;

    logic [ADDR_W-1:0]     rd_ptr;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    spi_eeprom_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk_50M),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            csn_sync <= 2'b11;
            sck_sync <= 2'b00;
            si_sync  <= 2'b00;
            csn_d    <= 1'b1;
            sck_d    <= 1'b0;
        end else begin
            csn_sync <= {csn_sync[0], spi_csn};
            sck_sync <= {sck_sync[0], spi_sck};
            si_sync  <= {si_sync[0], spi_si};
            csn_d    <= csn_sync[1];
            sck_d    <= sck_sync[1];
        end
    end

    assign csn_s     = csn_sync[1];
    assign sck_s     = sck_sync[1];
    assign si_s      = si_sync[1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign cs_rise   = csn_s & ~csn_d;
    assign cs_fall   = ~csn_s & csn_d;

    // The byte being completed this cycle, so a CS_N rise that coincides
    // with the 8th sck rise still sees the full byte.
    assign rx_byte   = {rx_sr, si_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);

    always_comb begin
        status         = '0;
        status[SR_WEL] = wel;
        status[SR_WIP] = wip;
    end

    assign tx_byte   = (state == ST_STAT) ? status : mem_rdata;
    assign busy      = wip;

    assign mem_we    = commit_act && pvalid[commit_idx];
    assign mem_waddr = {wr_page, commit_idx};
    assign mem_wdata = pbuf[commit_idx];

    always_comb begin
        eff_pend = PEND_NONE;
        if (state == ST_CMD && byte_done)
            eff_pend = cmd_pend(rx_byte, wip);
        else if (state == ST_WAITCS && !sck_rise)
            eff_pend = op_pend;
    end

    // Commit needs at least one full byte and no trailing partial byte.
    assign commit_go = cs_rise && (state == ST_WR_DATA)
                       && (got_byte || byte_done)
                       && (byte_done || (!sck_rise && bit_cnt == 3'd0));

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (csn_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall)   state_nxt = ST_CMD;
                ST_CMD:  if (byte_done) state_nxt = cmd_next_state(rx_byte, wel, wip);
                ST_ADDR: if (byte_done) state_nxt = is_write ? ST_WR_DATA : ST_RD_DATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            spi_so     <= 1'b0;
            spi_so_oe  <= 1'b0;
            wr_commit  <= 1'b0;
            op_pend    <= PEND_NONE;
            is_write   <= 1'b0;
            got_byte   <= 1'b0;
            wel        <= 1'b0;
            wip        <= 1'b0;
            wip_cnt    <= '0;
            pvalid     <= '0;
            wr_off     <= '0;
            wr_page    <= '0;
            commit_act <= 1'b0;
            commit_idx <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < PAGE_DEPTH; i++) pbuf[i] <= '0;
        end else begin
            wr_commit <= 1'b0;

            if (csn_s) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end

            case (state)
                ST_CMD: if (byte_done) begin
                    op_pend  <= cmd_pend(rx_byte, wip);
                    is_write <= (rx_byte == OP_WRITE);
                end
                ST_ADDR: if (byte_done) begin
                    rd_ptr   <= rx_byte[ADDR_W-1:0];
                    wr_page  <= rx_byte[ADDR_W-1:PAGE_W];
                    wr_off   <= rx_byte[PAGE_W-1:0];
                    pvalid   <= '0;
                    got_byte <= 1'b0;
                end
                ST_WR_DATA: if (byte_done) begin
                    pbuf[wr_off]   <= rx_byte;
                    pvalid[wr_off] <= 1'b1;
                    wr_off         <= wr_off + PAGE_W'(1);
                    got_byte       <= 1'b1;
                end
                ST_RD_DATA: if (byte_done) rd_ptr <= rd_ptr + ADDR_W'(1);
                ST_WAITCS:  if (sck_rise)  op_pend <= PEND_NONE;
                default: ;
            endcase

            if (csn_s) begin
                spi_so_oe <= 1'b0;
                spi_so    <= 1'b0;
            end else if (sck_fall && (state == ST_RD_DATA || state == ST_STAT)) begin
                spi_so_oe <= 1'b1;
                if (bit_cnt == 3'd0) begin
                    spi_so <= tx_byte[7];
                    tx_sr  <= tx_byte[6:0];
                end else begin
                    spi_so <= tx_sr[6];
                    tx_sr  <= {tx_sr[5:0], 1'b0};
                end
            end

            if (wip) begin
                wip_cnt <= wip_cnt - CNT_W'(1);
                if (wip_cnt == CNT_W'(1)) wip <= 1'b0;
            end

            if (commit_act) begin
                commit_idx <= commit_idx + PAGE_W'(1);
                if (commit_idx == '1) begin
                    commit_act <= 1'b0;
                    pvalid     <= '0;
                end
            end

            if (cs_rise) begin
                case (eff_pend)
                    PEND_WREN: wel <= 1'b1;
                    PEND_WRDI: wel <= 1'b0;
                    default: ;
                endcase
                if (commit_go) begin
                    wip        <= 1'b1;
                    wel        <= 1'b0;
                    wr_commit  <= 1'b1;
                    wip_cnt    <= CNT_W'(WRITE_CYCLES);
                    commit_act <= 1'b1;
                    commit_idx <= '0;
                end else if (state == ST_WR_DATA) begin
                    pvalid <= '0;
                end
                op_pend  <= PEND_NONE;
                got_byte <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Directed bench for spi_eeprom_slave acting as the SPI master (SCK = clk/10).
// Expected bytes are hand-derived from the command sequence below.
module tb_spi_eeprom_slave;

    logic clk_50M = 1'b0;
    logic reset, spi_csn, spi_sck, spi_si;
    logic spi_so, spi_so_oe, busy, wr_commit;

    int errors = 0;
    int checks = 0;
    int commit_cnt = 0;
    int commit_ref;
    logic [7:0] rd;

    spi_eeprom_slave #(.ADDR_W(7), .PAGE_W(4), .WRITE_CYCLES(100)) dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .spi_csn   (spi_csn),
        .spi_sck   (spi_sck),
        .spi_si    (spi_si),
        .spi_so    (spi_so),
        .spi_so_oe (spi_so_oe),
        .busy      (busy),
        .wr_commit (wr_commit)
    );

    always #5 clk_50M = ~clk_50M;

    always @(negedge clk_50M) if (wr_commit === 1'b1) commit_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_si = tx[7-i];
            repeat (5) @(negedge clk_50M);
            rx = {rx[6:0], spi_so};
            spi_sck = 1'b1;
            repeat (5) @(negedge clk_50M);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk_50M);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk_50M);
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] dummy;
        spi_csn = 1'b0;
        xfer(op, 8, dummy);
        cs_high();
    endtask

    task automatic rdsr(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        spi_csn = 1'b0;
        xfer(8'h05, 8, v);
        xfer(8'h00, 8, v);
        check(tag, v, exp);
        cs_high();
    endtask

    task automatic write1(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] dummy;
        spi_csn = 1'b0;
        xfer(8'h02, 8, dummy);
        xfer(addr, 8, dummy);
        xfer(data, 8, dummy);
        cs_high();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk_50M);
        check(tag, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        reset = 1'b1; spi_csn = 1'b1; spi_sck = 1'b0; spi_si = 1'b0;
        repeat (4) @(negedge clk_50M);
        check("rst_busy",   {7'd0, busy},      8'h00);
        check("rst_oe",     {7'd0, spi_so_oe}, 8'h00);
        check("rst_so",     {7'd0, spi_so},    8'h00);
        check("rst_commit", {7'd0, wr_commit}, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk_50M);

        // 1: status after reset, SO enable only in the data phase
        spi_csn = 1'b0;
        xfer(8'h05, 8, rd);
        check("oe_after_opcode", {7'd0, spi_so_oe}, 8'h00);
        xfer(8'h00, 8, rd);
        check("rdsr_reset", rd, 8'h00);
        check("oe_in_data", {7'd0, spi_so_oe}, 8'h01);
        xfer(8'h00, 8, rd);
        check("rdsr_repeat", rd, 8'h00);
        cs_high();
        check("oe_after_cs", {7'd0, spi_so_oe}, 8'h00);

        // 2: WEL control
        cmd1(8'h06);
        rdsr("rdsr_wren", 8'h02);
        cmd1(8'h04);
        rdsr("rdsr_wrdi", 8'h00);
        spi_csn = 1'b0;
        xfer(8'h06, 7, rd);
        cs_high();
        rdsr("rdsr_wren7", 8'h00);

        // 3: basic write, busy window, readback
        commit_ref = commit_cnt;
        cmd1(8'h06);
        write1(8'h00, 8'h78);
        check("commit_pulse", 8'(commit_cnt - commit_ref), 8'h01);
        check("busy_after_commit", {7'd0, busy}, 8'h01);
        rdsr("rdsr_busy", 8'h01);
        wait_idle("busy_clear_1");
        rdsr("rdsr_after_busy", 8'h00);
        spi_csn = 1'b0;
        xfer(8'h03, 8, rd);
        xfer(8'h00, 8, rd);
        check("oe_after_addr", {7'd0, spi_so_oe}, 8'h00);
        xfer(8'h00, 8, rd);
        check("read_00", rd, 8'h78);
        cs_high();

        cmd1(8'h06);
        write1(8'h01, 8'hFF);
        wait_idle("busy_clear_2");
        cmd1(8'h06);
        write1(8'h7F, 8'h5A);
        wait_idle("busy_clear_3");

        // 4: write without WREN is ignored
        commit_ref = commit_cnt;
        write1(8'h01, 8'h9A);
        check("no_commit_wel0", 8'(commit_cnt - commit_ref), 8'h00);
        spi_csn = 1'b0;
        xfer(8'h03, 8, rd);
        xfer(8'h01, 8, rd);
        xfer(8'h00, 8, rd);
        check("read_01", rd, 8'hFF);
        cs_high();
        rdsr("rdsr_no_wel", 8'h00);

        // 5: page wrap on write, array wrap on read
        cmd1(8'h06);
        spi_csn = 1'b0;
        xfer(8'h02, 8, rd);
        xfer(8'h0E, 8, rd);
        xfer(8'h11, 8, rd);
        xfer(8'h22, 8, rd);
        xfer(8'h33, 8, rd);
        cs_high();
        wait_idle("busy_clear_4");
        spi_csn = 1'b0;
        xfer(8'h03, 8, rd);
        xfer(8'h0E, 8, rd);
        xfer(8'h00, 8, rd);
        check("read_0E", rd, 8'h11);
        xfer(8'h00, 8, rd);
        check("read_0F", rd, 8'h22);
        cs_high();
        spi_csn = 1'b0;
        xfer(8'h03, 8, rd);
        xfer(8'h00, 8, rd);
        xfer(8'h00, 8, rd);
        check("read_00_wrapped", rd, 8'h33);
        cs_high();
        spi_csn = 1'b0;
        xfer(8'h03, 8, rd);
        xfer(8'h7F, 8, rd);
        xfer(8'h00, 8, rd);
        check("read_7F", rd, 8'h5A);
        xfer(8'h00, 8, rd);
        check("read_wrap_00", rd, 8'h33);
        cs_high();

        // 6: partial byte aborts, reset during busy
        commit_ref = commit_cnt;
        cmd1(8'h06);
        spi_csn = 1'b0;
        xfer(8'h02, 8, rd);
        xfer(8'h02, 8, rd);
        xfer(8'hBC, 8, rd);
        xfer(8'hA0, 3, rd);
        cs_high();
        check("no_commit_partial", 8'(commit_cnt - commit_ref), 8'h00);
        check("busy_partial", {7'd0, busy}, 8'h00);
        rdsr("rdsr_wel_kept", 8'h02);
        write1(8'h03, 8'h44);
        check("commit_final", 8'(commit_cnt - commit_ref), 8'h01);
        check("busy_final", {7'd0, busy}, 8'h01);
        reset = 1'b1;
        repeat (3) @(negedge clk_50M);
        check("busy_in_reset", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk_50M);
        check("busy_after_reset", {7'd0, busy}, 8'h00);
        rdsr("rdsr_after_reset", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
